// File: rtl/ram2_write_arbiter.sv
// Write-port owner for the 2R1W register-file RAM.
// Sweeps the array to INIT_VALUE, then arbitrates client writes round-robin.
module ram2_write_arbiter #(
  parameter int Width        = 8,
  parameter int AddressWidth = 4,
  parameter int Requesters   = 4,
  parameter int IdWidth      = 2,
  parameter logic [Width-1:0] INIT_VALUE = {Width{1'b0}}
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               clear,
  input  logic [Requesters-1:0]              req_valid,
  input  logic [Requesters*AddressWidth-1:0] req_addr,
  input  logic [Requesters*Width-1:0]        req_data,
  output logic [Requesters-1:0]              req_ready,
  output logic                               we,
  output logic [AddressWidth-1:0]            waddr,
  output logic [Width-1:0]                   D,
  output logic [IdWidth-1:0]                 gnt_id,
  output logic                               init_done
);

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [AddressWidth-1:0] cnt_q, cnt_d;
  logic [IdWidth-1:0]      ptr_q, ptr_d;
  logic                    we_q, we_d;
  logic [AddressWidth-1:0] waddr_q, waddr_d;
  logic [Width-1:0]        d_q, d_d;
  logic [IdWidth-1:0]      gid_q, gid_d;
  logic                    done_q, done_d;

  logic [AddressWidth-1:0] addr_a [Requesters];
  logic [Width-1:0]        data_a [Requesters];

  for (genvar g = 0; g < Requesters; g++) begin : g_unpack
    assign addr_a[g] = req_addr[g*AddressWidth +: AddressWidth];
    assign data_a[g] = req_data[g*Width +: Width];
  end

  function automatic logic [IdWidth-1:0] rot(
    input logic [IdWidth-1:0] p,
    input int                 o
  );
    int s;
    s = int'(p) + o;
    if (s >= Requesters) s = s - Requesters;
    return IdWidth'(s);
  endfunction

  logic                  active;
  logic                  hit;
  logic [IdWidth-1:0]    sel;
  logic [Requesters-1:0] gnt;

  assign active = (state_q == RUN) && !clear;

  // Rotating-priority pick: first valid client at or after ptr.
  always_comb begin
    hit = 1'b0;
    sel = '0;
    gnt = '0;
    for (int o = 0; o < Requesters; o++) begin
      if (!hit && req_valid[rot(ptr_q, o)]) begin
        hit = 1'b1;
        sel = rot(ptr_q, o);
      end
    end
    if (active && hit) gnt[sel] = 1'b1;
  end

  assign req_ready = gnt;

  // Next-state and next-output logic for sweep and arbitration.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    d_d     = d_q;
    gid_d   = gid_q;
    done_d  = done_q;
    unique case (state_q)
      INIT: begin
        gid_d = '0;
        if (clear) begin
          cnt_d = '0;
        end else begin
          we_d    = 1'b1;
          waddr_d = cnt_q;
          d_d     = INIT_VALUE;
          cnt_d   = cnt_q + 1'b1;
          if (&cnt_q) begin
            state_d = RUN;
            done_d  = 1'b1;
          end
        end
      end
      RUN: begin
        if (clear) begin
          state_d = INIT;
          cnt_d   = '0;
          done_d  = 1'b0;
          gid_d   = '0;
        end else if (hit) begin
          we_d    = 1'b1;
          waddr_d = addr_a[sel];
          d_d     = data_a[sel];
          gid_d   = sel;
          if (sel == IdWidth'(Requesters - 1))
            ptr_d = '0;
          else
            ptr_d = sel + 1'b1;
        end
      end
      default: state_d = INIT;
    endcase
  end

  // State and registered RAM-side outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
      ptr_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      d_q     <= '0;
      gid_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      d_q     <= d_d;
      gid_q   <= gid_d;
      done_q  <= done_d;
    end
  end

  assign we        = we_q;
  assign waddr     = waddr_q;
  assign D         = d_q;
  assign gnt_id    = gid_q;
  assign init_done = done_q;

endmodule

// File: tb/tb_ram2_write_arbiter.sv
// Bench for ram2_write_arbiter.
// Directed scenarios plus random traffic against a cycle-level model.
module tb_ram2_write_arbiter;
  localparam int W = 8;
  localparam int AW = 4;
  localparam int R = 4;
  localparam int IW = 2;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          clear;
  logic [R-1:0]  req_valid;
  logic [R*AW-1:0] req_addr;
  logic [R*W-1:0]  req_data;
  logic [R-1:0]  req_ready;
  logic          we;
  logic [AW-1:0] waddr;
  logic [W-1:0]  D;
  logic [IW-1:0] gnt_id;
  logic          init_done;

  ram2_write_arbiter #(
    .Width(W), .AddressWidth(AW), .Requesters(R),
    .IdWidth(IW), .INIT_VALUE(8'h00)
  ) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready),
    .we(we), .waddr(waddr), .D(D),
    .gnt_id(gnt_id), .init_done(init_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  int m_init, m_cnt, m_ptr;
  int m_we, m_waddr, m_d, m_gid, m_done;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h @%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic mreset();
    m_init = 1; m_cnt = 0; m_ptr = 0;
    m_we = 0; m_waddr = 0; m_d = 0;
    m_gid = 0; m_done = 0;
  endtask

  task automatic chk_out(input string tag);
    chk({tag, ".we"}, 32'(we), m_we);
    chk({tag, ".waddr"}, 32'(waddr), m_waddr);
    chk({tag, ".D"}, 32'(D), m_d);
    chk({tag, ".gnt_id"}, 32'(gnt_id), m_gid);
    chk({tag, ".init_done"}, 32'(init_done), m_done);
  endtask

  task automatic step(input string tag);
    int k;
    bit hit;
    logic [R-1:0] er;
    @(negedge clk);
    hit = 0;
    k = 0;
    for (int o = 0; o < R; o++) begin
      int c;
      c = (m_ptr + o) % R;
      if (!hit && req_valid[c]) begin
        hit = 1;
        k = c;
      end
    end
    er = (!m_init && !clear && hit) ? 4'(1 << k) : 4'b0;
    chk({tag, ".ready"}, 32'(req_ready), 32'(er));
    @(posedge clk);
    if (m_init != 0) begin
      m_gid = 0;
      if (clear) begin
        m_we = 0;
        m_cnt = 0;
      end else begin
        m_we = 1;
        m_waddr = m_cnt;
        m_d = 0;
        if (m_cnt == DEPTH - 1) begin
          m_init = 0;
          m_done = 1;
        end
        m_cnt = (m_cnt + 1) % DEPTH;
      end
    end else if (clear) begin
      m_init = 1; m_cnt = 0; m_done = 0;
      m_we = 0; m_gid = 0;
    end else if (hit) begin
      m_we = 1;
      m_waddr = int'(req_addr[k*AW +: AW]);
      m_d = int'(req_data[k*W +: W]);
      m_gid = k;
      m_ptr = (k + 1) % R;
    end else begin
      m_we = 0;
    end
    #1;
    chk_out(tag);
  endtask

  task automatic set_req(input int c, input logic [3:0] a,
                         input logic [7:0] d);
    req_addr[c*AW +: AW] = a;
    req_data[c*W +: W] = d;
  endtask

  initial begin
    rst = 1'b0;
    clear = 1'b0;
    req_valid = '0;
    req_addr = '0;
    req_data = '0;
    mreset();
    #6;
    chk_out("reset");
    rst = 1'b1;

    for (int i = 0; i < DEPTH; i++) step("sweep");
    chk("sweep_ptr_run", 32'(m_init), 0);
    step("idle");

    set_req(2, 4'h5, 8'hA5);
    req_valid = 4'b0100;
    step("c2");
    req_valid = 4'b1000;
    set_req(3, 4'h9, 8'h3C);
    step("c3");

    for (int c = 0; c < R; c++)
      set_req(c, 4'(c + 8), 8'(8'h10 * c + 1));
    req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) step("all");

    req_valid = 4'b0010;
    step("c1");
    req_valid = 4'b1001;
    step("p2a");
    step("p2b");
    chk("ptr_end", 32'(m_ptr), 1);
    req_valid = '0;
    step("idle2");

    req_valid = 4'b0010;
    clear = 1'b1;
    step("clr_run");
    clear = 1'b0;
    for (int i = 0; i < DEPTH; i++) step("resweep");
    step("after_clr");
    req_valid = '0;

    clear = 1'b1;
    step("clr2");
    clear = 1'b0;
    for (int i = 0; i < 5; i++) step("part");
    clear = 1'b1;
    for (int i = 0; i < 3; i++) step("hold");
    clear = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) step("near");
    clear = 1'b1;
    step("last_clr");
    clear = 1'b0;
    for (int i = 0; i < DEPTH; i++) step("full");

    clear = 1'b1;
    step("clr3");
    clear = 1'b0;
    for (int i = 0; i < 7; i++) step("mid");
    chk("mid_cnt", 32'(m_cnt), 7);
    rst = 1'b0;
    #1;
    mreset();
    chk_out("async_rst");
    #1;
    rst = 1'b1;
    for (int i = 0; i < DEPTH; i++) step("rst_sweep");

    for (int i = 0; i < 400; i++) begin
      req_valid = 4'($urandom_range(0, 15));
      req_addr = 16'($urandom);
      req_data = 32'($urandom);
      clear = ($urandom_range(0, 39) == 0);
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
